traffic_ctrl_param: RTL

- Parametrised two-road traffic-light controller.
- Successor to the fixed-timing top-level FSM plus countdown path.
- Generates its own 1 s tick from the board clock and sequences six timed phases with configurable durations.
- Outputs the six lamp LEDs and a per-road countdown (binary and BCD tens/ones) for the 7-segment drivers. Adds a night flashing-yellow mode.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/traffic_ctrl_param_tick_gen.sv | 29 ++
 rtl/traffic_ctrl_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the parametrised two-road traffic controller.
// Optional pedestrian shortening in traffic_ctrl_param is guarded by PED_REQ_EN.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_G1    = 3'd0,
    ST_Y1    = 3'd1,
    ST_AR1   = 3'd2,
    ST_G2    = 3'd3,
    ST_Y2    = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6
  } state_t;

  // LED bit positions inside the 6-bit lamp bus
  localparam int LED_R1_RED = 5;
  localparam int LED_R1_YEL = 4;
  localparam int LED_R1_GRN = 3;
  localparam int LED_R2_RED = 2;
  localparam int LED_R2_YEL = 1;
  localparam int LED_R2_GRN = 0;

  localparam logic [5:0] LEDS_G1  = (6'b1 << LED_R1_GRN) | (6'b1 << LED_R2_RED);
  localparam logic [5:0] LEDS_Y1  = (6'b1 << LED_R1_YEL) | (6'b1 << LED_R2_RED);
  localparam logic [5:0] LEDS_AR  = (6'b1 << LED_R1_RED) | (6'b1 << LED_R2_RED);
  localparam logic [5:0] LEDS_G2  = (6'b1 << LED_R1_RED) | (6'b1 << LED_R2_GRN);
  localparam logic [5:0] LEDS_Y2  = (6'b1 << LED_R1_RED) | (6'b1 << LED_R2_YEL);
  localparam logic [5:0] LEDS_OFF = 6'b000000;

  // Two-digit BCD; anything that does not fit saturates to 99.
  function automatic logic [7:0] bin_to_bcd(input int unsigned value);
    int unsigned tens;
    int unsigned ones;
    if (value > 99) return 8'h99;
    tens = value / 10;
    ones = value % 10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/traffic_ctrl_param_tick_gen.sv
// Divides the board clock down to a one-cycle tick strobe at TICK_HZ.
// The strobe is registered: it is high in the cycle right after the divider wraps.
module tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_LAST);
      if (div == DIV_LAST) div <= '0;
      else                 div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller with timed phases, per-road countdowns and
// night flashing-yellow mode. Define PED_REQ_EN to enable pedestrian green shortening.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int GREEN1_S  = 25,
  parameter int GREEN2_S  = 20,
  parameter int YELLOW_S  = 3,
  parameter int ALLRED_S  = 1,
  parameter int PED_MIN_S = 5,
  parameter int CNT_W     = 7
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic [5:0]       LEDS,
  output logic [CNT_W-1:0] cnt_r1,
  output logic [CNT_W-1:0] cnt_r2,
  output logic [7:0]       bcd_r1,
  output logic [7:0]       bcd_r2,
  output logic             tick
);

  localparam logic [CNT_W-1:0] T_G1  = CNT_W'(GREEN1_S);
  localparam logic [CNT_W-1:0] T_G2  = CNT_W'(GREEN2_S);
  localparam logic [CNT_W-1:0] T_Y   = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALLRED_S);
  localparam logic [CNT_W-1:0] T_YA  = CNT_W'(YELLOW_S + ALLRED_S);
  localparam logic [CNT_W-1:0] T_PED = CNT_W'(PED_MIN_S);
  localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             toggle, toggle_n;
  logic             ped_pend;
  logic [5:0]       leds_n;
  logic [CNT_W-1:0] cnt_r1_n, cnt_r2_n;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk_50M),
    .rst_n(rst_n),
    .tick (tick)
  );

  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_G1:   return ST_Y1;
      ST_Y1:   return ST_AR1;
      ST_AR1:  return ST_G2;
      ST_G2:   return ST_Y2;
      ST_Y2:   return ST_AR2;
      default: return ST_G1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      ST_G1:         return T_G1;
      ST_G2:         return T_G2;
      ST_Y1, ST_Y2:  return T_Y;
      ST_AR1, ST_AR2: return T_AR;
      default:       return '0;
    endcase
  endfunction

  // Night mode outranks phase expiry, which outranks the pedestrian shortcut.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    toggle_n = toggle;
    if (tick) begin
      if (night_mode) begin
        if (state != ST_FLASH) begin
          state_n  = ST_FLASH;
          timer_n  = '0;
          toggle_n = 1'b1;
        end else begin
          toggle_n = ~toggle;
        end
      end else if (state == ST_FLASH) begin
        state_n = ST_AR2;
        timer_n = T_AR;
      end else if (ped_pend && (state == ST_G1 || state == ST_G2) && (timer > T_PED)) begin
        timer_n = T_PED;
      end else if (timer > T_ONE) begin
        timer_n = timer - T_ONE;
      end else begin
        state_n = next_phase(state);
        timer_n = phase_len(next_phase(state));
      end
    end
  end

  // A red road counts down to its own next green, through the other road's phases.
  always_comb begin
    leds_n   = LEDS_AR;
    cnt_r1_n = '0;
    cnt_r2_n = '0;
    case (state_n)
      ST_G1: begin
        leds_n   = LEDS_G1;
        cnt_r1_n = timer_n;
        cnt_r2_n = timer_n + T_YA;
      end
      ST_Y1: begin
        leds_n   = LEDS_Y1;
        cnt_r1_n = timer_n;
        cnt_r2_n = timer_n + T_AR;
      end
      ST_AR1, ST_AR2: begin
        leds_n   = LEDS_AR;
        cnt_r1_n = timer_n;
        cnt_r2_n = timer_n;
      end
      ST_G2: begin
        leds_n   = LEDS_G2;
        cnt_r1_n = timer_n + T_YA;
        cnt_r2_n = timer_n;
      end
      ST_Y2: begin
        leds_n   = LEDS_Y2;
        cnt_r1_n = timer_n + T_AR;
        cnt_r2_n = timer_n;
      end
      ST_FLASH: begin
        leds_n             = LEDS_OFF;
        leds_n[LED_R1_YEL] = toggle_n;
        leds_n[LED_R2_YEL] = toggle_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_G1;
      timer  <= T_G1;
      toggle <= 1'b0;
      LEDS   <= LEDS_G1;
      cnt_r1 <= T_G1;
      cnt_r2 <= T_G1 + T_YA;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      toggle <= toggle_n;
      LEDS   <= leds_n;
      cnt_r1 <= cnt_r1_n;
      cnt_r2 <= cnt_r2_n;
    end
  end

`ifdef PED_REQ_EN
  logic pend_clear;
  assign pend_clear = (state_n != state) &&
                      (state_n == ST_Y1 || state_n == ST_Y2 || state_n == ST_FLASH);

  // A request arriving in the same cycle as the clear survives it.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)          ped_pend <= 1'b0;
    else if (ped_req)    ped_pend <= 1'b1;
    else if (pend_clear) ped_pend <= 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
`endif

  assign bcd_r1 = bin_to_bcd(32'(cnt_r1));
  assign bcd_r2 = bin_to_bcd(32'(cnt_r2));

endmodule
